// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of the 4-bit ALU: command FIFO, carry flag owner,
// carry-hazard hold, illegal-opcode filter and lost-response watchdog.
module alu_cmd_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_ctl,
  input  logic       flag_clr,
  output logic       valid_in,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [3:0] ctl,
  input  logic       alu_valid_out,
  input  logic       alu_carry,
  output logic       carry_flag,
  output logic       busy,
  output logic       illegal_err,
  output logic       timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ctl;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    outstanding;
  logic [7:0]    wd_cnt, wd_inc;
  state_t        state, state_nxt;
  cmd_t          head;
  logic          push, pop, do_issue, do_illegal;
  logic          head_carry, head_illegal, ret, wd_fire;

  assign cmd_ready    = (count < FULL);
  assign push         = cmd_valid && cmd_ready;
  assign head         = mem[rd_ptr];
  assign head_illegal = (head.ctl[3:1] == 3'b111);
  assign head_carry   = head.ctl inside {4'b0100, 4'b0110, 4'b1100, 4'b1101};
  assign ret          = alu_valid_out && (outstanding != 4'd0);
  assign busy         = (count != '0) || (outstanding != 4'd0);
  assign wd_inc       = wd_cnt + 8'd1;
  assign wd_fire      = (outstanding != 4'd0) && !alu_valid_out && (wd_inc == 8'(TIMEOUT));

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt  = state;
    pop        = 1'b0;
    do_issue   = 1'b0;
    do_illegal = 1'b0;
    case (state)
      IDLE: if (push || count != '0) state_nxt = ISSUE;
      ISSUE: begin
        if (count == '0) begin
          state_nxt = IDLE;
        end else if (head_illegal) begin
          pop        = 1'b1;
          do_illegal = 1'b1;
        end else if (head_carry && outstanding != 4'd0) begin
          state_nxt = HOLD;
        end else if (outstanding != 4'hF) begin
          pop      = 1'b1;
          do_issue = 1'b1;
        end
        if (pop && count == ONE && !push) state_nxt = IDLE;
      end
      // The bubble after outstanding hits 0 lets cin come from the updated register.
      HOLD: if (outstanding == 4'd0) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: storage array is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, ctl: cmd_ctl};
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= 4'd0;
      wd_cnt      <= 8'd0;
      carry_flag  <= 1'b0;
      valid_in    <= 1'b0;
      a           <= 4'd0;
      b           <= 4'd0;
      ctl         <= 4'd0;
      cin         <= 1'b0;
      illegal_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      valid_in    <= do_issue;
      illegal_err <= do_illegal;
      timeout_err <= wd_fire;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      if (do_issue) begin
        a   <= head.a;
        b   <= head.b;
        ctl <= head.ctl;
        cin <= carry_flag;
      end

      if (flag_clr) carry_flag <= 1'b0;
      else if (ret) carry_flag <= alu_carry;

      // A timeout abandons everything in flight, but an op issued on that same edge is still live.
      if (wd_fire)                outstanding <= {3'b000, do_issue};
      else if (do_issue && !ret)  outstanding <= outstanding + 4'd1;
      else if (!do_issue && ret)  outstanding <= outstanding - 4'd1;

      if (outstanding == 4'd0 || alu_valid_out || wd_fire) wd_cnt <= 8'd0;
      else                                                 wd_cnt <= wd_inc;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: stimulus pushes expected issues into a
// scoreboard queue; a negedge monitor pops and compares every valid_in beat.
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_ctl;
  logic       flag_clr;
  logic       valid_in, cin;
  logic [3:0] a, b, ctl;
  logic       alu_valid_out, alu_carry;
  logic       carry_flag, busy, illegal_err, timeout_err;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctl(cmd_ctl),
    .flag_clr(flag_clr),
    .valid_in(valid_in), .a(a), .b(b), .cin(cin), .ctl(ctl),
    .alu_valid_out(alu_valid_out), .alu_carry(alu_carry),
    .carry_flag(carry_flag), .busy(busy),
    .illegal_err(illegal_err), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ctl;
    logic       cin;
  } iss_t;

  iss_t exp_q[$];
  int   issue_cyc_q[$];
  bit   carry_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  bit   alu_en = 1'b0, clr_on_ret = 1'b0;
  int   illegal_cnt = 0, timeout_cnt = 0, timeout_cyc = 0, ret_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every issue beat must match the head of the scoreboard.
  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (valid_in) begin
          issue_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) fail("unexpected_issue", int'({a, b, ctl, cin}), -1);
          else begin
            e = exp_q.pop_front();
            check("issue", {a, b, ctl, cin}, e);
          end
        end
        if (illegal_err) illegal_cnt++;
        if (timeout_err) begin
          timeout_cnt++;
          timeout_cyc = cyc;
        end
      end
    end
  end

  // ALU model: returns one cycle after each issue beat while alu_en is set.
  initial begin
    bit pend = 1'b0, pend_c = 1'b0, pend_clr = 1'b0;
    alu_valid_out = 1'b0;
    alu_carry     = 1'b0;
    flag_clr      = 1'b0;
    forever begin
      @(negedge clk);
      alu_valid_out = 1'b0;
      flag_clr      = 1'b0;
      if (pend) begin
        alu_valid_out = 1'b1;
        alu_carry     = pend_c;
        flag_clr      = pend_clr;
        ret_cyc       = cyc + 1;
        pend          = 1'b0;
      end
      if (!reset && valid_in && alu_en) begin
        pend     = 1'b1;
        pend_c   = (carry_q.size() != 0) ? carry_q.pop_front() : 1'b0;
        pend_clr = clr_on_ret;
      end
    end
  end

  task automatic expect_issue(input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] ec, input logic ecin);
    iss_t e;
    e.a = ea; e.b = eb; e.ctl = ec; e.cin = ecin;
    exp_q.push_back(e);
  endtask

  task automatic push_cmd(input logic [3:0] pa, input logic [3:0] pb,
                          input logic [3:0] pc, output int acc_cyc);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = pa; cmd_b = pb; cmd_ctl = pc;
    while (!cmd_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      fail("push_stall", n, 60);
      acc_cyc = -1;
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issues(input string name, input int target, input int bound);
    int n = 0;
    while (issue_cyc_q.size() < target && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, issue_cyc_q.size(), target);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, busy, 1'b0);
    check({name, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t", $time);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int acc, base, il0, to0, c1_idx;
    logic [3:0] ctl_tab [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h7};

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_ctl = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_valid_in", valid_in, 1'b0);
    check("rst_bus", {a, b, ctl, cin}, 13'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {carry_flag, illegal_err, timeout_err}, 3'b000);

    // 1: single ADD, latency of two edges from accept to valid_in.
    alu_en = 1'b1;
    carry_q.push_back(1'b0);
    expect_issue(4'h3, 4'h4, 4'b0011, 1'b0);
    base = issue_cyc_q.size();
    push_cmd(4'h3, 4'h4, 4'b0011, acc);
    wait_issues("t1_issue", base + 1, 10);
    if (issue_cyc_q.size() > base) check("t1_latency", issue_cyc_q[base] - acc, 1);
    wait_idle("t1_idle");
    check("t1_flag", carry_flag, 1'b0);

    // 2: ADD F+1 returns carry 1; ADC must hold and pick up cin=1.
    carry_q.push_back(1'b1);
    carry_q.push_back(1'b0);
    expect_issue(4'hF, 4'h1, 4'b0011, 1'b0);
    expect_issue(4'h1, 4'h1, 4'b0100, 1'b1);
    base = issue_cyc_q.size();
    push_cmd(4'hF, 4'h1, 4'b0011, acc);
    push_cmd(4'h1, 4'h1, 4'b0100, acc);
    wait_issues("t2_issue", base + 2, 30);
    if (issue_cyc_q.size() > base + 1)
      check("t2_hold_bubble", issue_cyc_q[base + 1] >= ret_cyc + 1, 1'b1);
    check("t2_flag", carry_flag, 1'b1);
    wait_idle("t2_idle");

    // 3: fill FIFO behind a held carry user, no pass-through, then wrap.
    alu_en = 1'b0;
    expect_issue(4'h1, 4'h1, 4'h1, 1'b0);
    expect_issue(4'h2, 4'h2, 4'h6, 1'b0);
    expect_issue(4'h3, 4'h3, 4'h0, 1'b0);
    expect_issue(4'h4, 4'h4, 4'h5, 1'b0);
    expect_issue(4'h5, 4'h5, 4'h7, 1'b0);
    expect_issue(4'h6, 4'h6, 4'h9, 1'b0);
    base = issue_cyc_q.size();
    c1_idx = base + 1;
    push_cmd(4'h1, 4'h1, 4'h1, acc);
    push_cmd(4'h2, 4'h2, 4'h6, acc);
    push_cmd(4'h3, 4'h3, 4'h0, acc);
    push_cmd(4'h4, 4'h4, 4'h5, acc);
    push_cmd(4'h5, 4'h5, 4'h7, acc);
    check("t3_full_ready", cmd_ready, 1'b0);
    push_cmd(4'h6, 4'h6, 4'h9, acc);
    if (issue_cyc_q.size() > c1_idx) check("t3_no_passthru", acc > issue_cyc_q[c1_idx], 1'b1);
    else fail("t3_c1_not_issued", issue_cyc_q.size(), c1_idx + 1);
    alu_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      expect_issue(4'(i), 4'(15 - i), ctl_tab[i % 6], 1'b0);
      push_cmd(4'(i), 4'(15 - i), ctl_tab[i % 6], acc);
    end
    wait_idle("t3_idle");

    // 4: illegal opcode between two ORs is dropped with one pulse.
    il0 = illegal_cnt;
    base = issue_cyc_q.size();
    expect_issue(4'h1, 4'h2, 4'b1000, 1'b0);
    expect_issue(4'h3, 4'h4, 4'b1000, 1'b0);
    push_cmd(4'h1, 4'h2, 4'b1000, acc);
    push_cmd(4'h0, 4'h0, 4'b1110, acc);
    push_cmd(4'h3, 4'h4, 4'b1000, acc);
    wait_idle("t4_idle");
    check("t4_illegal_pulses", illegal_cnt - il0, 1);
    check("t4_issue_count", issue_cyc_q.size() - base, 2);

    // flag_clr wins over a same-cycle carry return.
    clr_on_ret = 1'b1;
    carry_q.push_back(1'b1);
    expect_issue(4'h8, 4'h8, 4'b0011, 1'b0);
    push_cmd(4'h8, 4'h8, 4'b0011, acc);
    wait_idle("t4b_idle");
    clr_on_ret = 1'b0;
    check("t4b_clr_priority", carry_flag, 1'b0);
    carry_q.push_back(1'b1);
    expect_issue(4'hF, 4'hF, 4'b0011, 1'b0);
    push_cmd(4'hF, 4'hF, 4'b0011, acc);
    wait_idle("t4c_idle");
    check("t4c_flag_set", carry_flag, 1'b1);

    // 5: lost XOR response; watchdog releases RLC with the pre-timeout carry.
    alu_en = 1'b0;
    to0 = timeout_cnt;
    base = issue_cyc_q.size();
    carry_q.push_back(1'b1);
    expect_issue(4'h5, 4'h6, 4'b0010, 1'b1);
    expect_issue(4'h9, 4'h0, 4'b1100, 1'b1);
    push_cmd(4'h5, 4'h6, 4'b0010, acc);
    push_cmd(4'h9, 4'h0, 4'b1100, acc);
    wait_issues("t5_xor_issue", base + 1, 10);
    alu_en = 1'b1;
    wait_issues("t5_rlc_issue", base + 2, 40);
    check("t5_timeout_pulses", timeout_cnt - to0, 1);
    if (issue_cyc_q.size() > base + 1) begin
      check("t5_timeout_delay", timeout_cyc - issue_cyc_q[base], 8);
      check("t5_rlc_after_timeout", issue_cyc_q[base + 1] > timeout_cyc, 1'b1);
    end
    wait_idle("t5_idle");
    check("t5_flag", carry_flag, 1'b1);

    // 6: reset while holding with three entries queued.
    alu_en = 1'b0;
    base = issue_cyc_q.size();
    expect_issue(4'h7, 4'h7, 4'b0010, 1'b1);
    push_cmd(4'h7, 4'h7, 4'b0010, acc);
    push_cmd(4'h1, 4'h2, 4'b0100, acc);
    push_cmd(4'h3, 4'h3, 4'b0001, acc);
    push_cmd(4'h4, 4'h4, 4'b0001, acc);
    wait_issues("t6_xor_issue", base + 1, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("t6_valid_in", valid_in, 1'b0);
    check("t6_bus", {a, b, ctl, cin}, 13'd0);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_flags", {carry_flag, illegal_err, timeout_err}, 3'b000);
    alu_en = 1'b1;
    base = issue_cyc_q.size();
    expect_issue(4'hA, 4'h5, 4'b0011, 1'b0);
    push_cmd(4'hA, 4'h5, 4'b0011, acc);
    wait_issues("t6_post_issue", base + 1, 10);
    if (issue_cyc_q.size() > base) check("t6_latency", issue_cyc_q[base] - acc, 1);
    wait_idle("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
